tdm_demux18: RTL and testbench
==============================

Name: tdm_demux18

Overview:
- Receive end of the 8:1 select path: takes the single-bit stream a time-division 8:1 multiplexer produces and reassembles it.
- A 3-bit slot counter plays the role of the mux select; bit sent in slot k goes back to channel k.
- Sits between the serial link and the parallel channel consumers. Delivers one 8-bit parallel word per completed frame and flags framing errors.

Parameters:
- NCH, 8, number of channels/slots per frame; fixed power of two.
- SELW, 3, slot counter width, log2(NCH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- din_valid  input  1  serial bit on din is valid this cycle.
- din  input  1  serial data bit.
- frame_sync  input  1  qualified by din_valid; marks the slot-0 bit of a frame.
- dout  output  NCH  last complete frame; dout[k] = bit received in slot k.
- dout_valid  output  1  one-cycle pulse when dout updates.
- ch_stb  output  NCH  registered one-hot; bit k pulses the cycle after slot k is written.
- slot  output  SELW  current expected slot, i.e. demux select.
- locked  output  1  high in ACTIVE state.
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst_n low, async): state=HUNT, slot=0, shadow=0, dout=0, dout_valid=0, ch_stb=0, locked=0, frame_err=0.
- Only din_valid cycles act. Idle cycles hold all state; pulse outputs return to 0.
- HUNT:
  - Ignore beats with frame_sync=0.
  - Beat with frame_sync=1: shadow[0]<=din, slot<=1, state<=ACTIVE.
- ACTIVE, beat at slot s (1..NCH-2):
  - frame_sync=0: shadow[s]<=din, slot<=s+1.
- ACTIVE, beat at slot NCH-1:
  - frame_sync=0: dout<={din, shadow[NCH-2:0]}, dout_valid=1 next cycle, slot wraps to 0.
  - Latency: 1 cycle from the last-slot beat edge to dout/dout_valid.
- ACTIVE, beat at slot 0:
  - frame_sync=1: shadow[0]<=din, slot<=1.
  - frame_sync=0: lost alignment. frame_err pulse, beat discarded, state<=HUNT, slot<=0.
- ACTIVE, frame_sync=1 at slot s≠0 (early sync):
  - frame_err pulse; partial frame discarded, dout unchanged.
  - Beat taken as new slot 0: shadow[0]<=din, slot<=1, stay ACTIVE.
- ch_stb:
  - One-hot of the slot written, registered, 1 cycle after the beat.
  - Zero on idle cycles, on discarded beats, and in HUNT except the sync beat (ch_stb[0]).
- dout holds its value until the next complete frame. shadow bits are never partially visible on dout.
- Back-to-back frames with din_valid held high give dout_valid every NCH cycles with no bubble.
- Reset mid-frame: partial frame lost; dout cleared to 0.
- locked = (state==ACTIVE), registered with the state.

Decomposition:
- Shared package tdm18_pkg holds:
  - NCH, SELW;
  - state encoding HUNT=1'b0, ACTIVE=1'b1;
  - SLOT_LAST=NCH-1.
- One natural sub-module, dmux18: combinational 1:NCH one-hot decoder from slot+enable to a write strobe vector. It is reused for the shadow write enables and for ch_stb.

Test Plan:
- Reset, then frame 0xA5 sent LSB first (slot0 bit=1 with sync, then 0,1,0,0,1,0,1) with din_valid continuous → dout=8'hA5, dout_valid one pulse 1 cycle after the 8th beat; locked=1 from the cycle after the first beat.
- Frames 0x3C then 0xFF back-to-back → dout_valid pulses exactly 8 cycles apart; dout=3C then FF; frame_err never set.
- Frame 0x81 with din_valid dropped for 3 idle cycles after slot 4 → dout=8'h81; slot holds at 5 during the gap; ch_stb=0 during the gap.
- Sync reasserted at slot 5 mid-frame, then full frame 0x5A → frame_err pulse at the resync; no dout_valid for the aborted frame; dout=8'h5A afterwards.
- Frame 0x12 completes, next beat has frame_sync=0 → frame_err pulse, locked=0, dout stays 8'h12; beats without sync are ignored until the next sync.
- rst_n pulsed low asynchronously (not edge-aligned) at slot 3 → all outputs 0 immediately; the following full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/tdm18_pkg.sv
// Shared constants and state encoding for the 8-slot TDM receive demux.
package tdm18_pkg;
  localparam int NCH       = 8;
  localparam int SELW      = 3;
  localparam int SLOT_LAST = NCH - 1;

  typedef enum logic {
    HUNT   = 1'b0,
    ACTIVE = 1'b1
  } state_t;
endpackage

// File: rtl/dmux18.sv
// 1:NCH one-hot decoder: drives strobe k when enabled and select equals k.
module dmux18
  import tdm18_pkg::*;
(
  input  logic [SELW-1:0] sel,
  input  logic            en,
  output logic [NCH-1:0]  stb
);
  for (genvar k = 0; k < NCH; k++) begin : g_dec
    assign stb[k] = en && (sel == SELW'(k));
  end
endmodule

// File: rtl/tdm_demux18.sv
// TDM 1:8 receive demux: realigns a serial slot stream into one parallel word per
// frame, with sync hunting and framing-error detection.
module tdm_demux18
  import tdm18_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            din_valid,
  input  logic            din,
  input  logic            frame_sync,
  output logic [NCH-1:0]  dout,
  output logic            dout_valid,
  output logic [NCH-1:0]  ch_stb,
  output logic [SELW-1:0] slot,
  output logic            locked,
  output logic            frame_err
);
  state_t          state, state_nxt;
  logic [SELW-1:0] slot_nxt, wr_slot;
  logic            wr_en, done, err;
  logic [NCH-1:0]  wr_stb;
  logic [NCH-2:0]  shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  // A sync beat always restarts the frame at slot 0; it is an error only if it
  // cuts an in-progress frame short.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    wr_en     = 1'b0;
    wr_slot   = slot;
    done      = 1'b0;
    err       = 1'b0;
    if (din_valid) begin
      if (frame_sync) begin
        state_nxt = ACTIVE;
        wr_en     = 1'b1;
        wr_slot   = '0;
        slot_nxt  = SELW'(1);
        err       = (state == ACTIVE) && (slot != '0);
      end else if (state == ACTIVE) begin
        if (slot == '0) begin
          state_nxt = HUNT;
          slot_nxt  = '0;
          err       = 1'b1;
        end else begin
          wr_en    = 1'b1;
          slot_nxt = slot + SELW'(1);
          done     = (slot == SELW'(SLOT_LAST));
        end
      end
    end
  end

  always_comb begin
    locked = (state == ACTIVE);
  end

  dmux18 u_dmux (
    .sel (wr_slot),
    .en  (wr_en),
    .stb (wr_stb)
  );

  // Last slot bit bypasses the shadow straight into dout so the word lands in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ch_stb     <= '0;
      frame_err  <= 1'b0;
    end else begin
      for (int k = 0; k < NCH - 1; k++)
        if (wr_stb[k]) shadow[k] <= din;
      if (done) dout <= {din, shadow};
      dout_valid <= done;
      ch_stb     <= wr_stb;
      frame_err  <= err;
    end
  end
endmodule

// File: tb/tb_tdm_demux18.sv
// Directed test-plan sequences plus random traffic against a frame-level reference model.
module tb_tdm_demux18;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_valid = 1'b0, din = 1'b0, frame_sync = 1'b0;
  logic [7:0] dout, ch_stb;
  logic       dout_valid, locked, frame_err;
  logic [2:0] slot;

  int n_chk = 0, n_fail = 0;

  // reference model: lock flag, position within frame, collected bits
  bit       m_locked = 0;
  int       m_pos = 0;
  bit [7:0] m_bits = '0, m_dout = '0, m_stb = '0;
  bit       m_dv = 0, m_err = 0;

  tdm_demux18 dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .frame_sync(frame_sync), .dout(dout), .dout_valid(dout_valid),
    .ch_stb(ch_stb), .slot(slot), .locked(locked), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("dout", 32'(dout), 32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_dv));
    chk("ch_stb", 32'(ch_stb), 32'(m_stb));
    chk("slot", 32'(slot), 32'(m_pos));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("frame_err", 32'(frame_err), 32'(m_err));
  endtask

  task automatic model_reset();
    m_locked = 0; m_pos = 0; m_bits = '0; m_dout = '0;
    m_stb = '0; m_dv = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit s);
    m_dv = 0; m_stb = '0; m_err = 0;
    if (!v) return;
    if (s) begin
      if (m_locked && m_pos != 0) m_err = 1;
      m_locked = 1; m_bits[0] = d; m_stb = 8'd1; m_pos = 1;
    end else if (m_locked) begin
      if (m_pos == 0) begin
        m_err = 1; m_locked = 0;
      end else begin
        m_bits[m_pos] = d;
        m_stb = 8'd1 << m_pos;
        if (m_pos == 7) begin
          m_dout = m_bits; m_dv = 1; m_pos = 0;
        end else m_pos++;
      end
    end
  endtask

  task automatic beat(input bit v, input bit d, input bit s);
    @(negedge clk);
    din_valid = v; din = d; frame_sync = s;
    @(posedge clk);
    model_step(v, d, s);
    #1 chk_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, 1'($urandom), 1'($urandom));
  endtask

  // sends slots 0..nslots-1 of val, optionally inserting idle cycles after slot gap_at
  task automatic send(input logic [7:0] val, input int nslots, input int gap_at, input int ngap);
    for (int i = 0; i < nslots; i++) begin
      beat(1, val[i], i == 0);
      if (i == gap_at) idle(ngap);
    end
  endtask

  initial begin
    logic [7:0] v;
    #12;
    chk_all();
    @(negedge clk) rst_n = 1'b1;

    send(8'hA5, 8, -1, 0);
    chk("a5_dout", 32'(dout), 32'hA5);
    send(8'h3C, 8, -1, 0);
    send(8'hFF, 8, -1, 0);
    chk("ff_dout", 32'(dout), 32'hFF);
    send(8'h81, 8, 4, 3);
    chk("81_dout", 32'(dout), 32'h81);
    send(8'h77, 5, -1, 0);
    send(8'h5A, 8, -1, 0);
    chk("5a_dout", 32'(dout), 32'h5A);
    send(8'h12, 8, -1, 0);
    beat(1, 1, 0);
    chk("lost_lock", 32'(locked), 32'h0);
    for (int i = 0; i < 5; i++) beat(1, 1'($urandom), 0);
    chk("hold_12", 32'(dout), 32'h12);

    send(8'h99, 3, -1, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1 chk_all();
    @(negedge clk) rst_n = 1'b1;
    din_valid = 0;
    send(8'hC3, 8, -1, 0);
    chk("c3_dout", 32'(dout), 32'hC3);

    // random traffic: mostly aligned frames with occasional idles, misplaced and missing syncs
    for (int f = 0; f < 200; f++) begin
      v = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        bit s;
        s = (i == 0);
        if ($urandom_range(0, 19) == 0) s = ~s;
        beat(1, v[i], s);
        if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
